auth_msg_serializer: RTL and testbench
======================================

Name: auth_msg_serializer

Overview:
- Downstream of the error-response generator and the other authentication response builders.
- Detects a new message on MSG_ready and latches the 4-byte header.
- Streams the header MSB-first, then payload_len payload bytes fetched from the payload buffer, as a valid/ready byte stream toward the PD extended-message transmit buffer.
- One message in flight; accepts the next only after completion.

Parameters:
- MAX_PAYLOAD, 256, largest payload byte count accepted; larger requests are rejected.
- LEN_W, 9, width of payload_len and payload_addr; must satisfy 2^LEN_W > MAX_PAYLOAD.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MSG_ready  input  1  level from the message builder; a 0->1 transition (as sampled) starts a message.
- header  input  `SIZE_OF_HEADER_VARS*`SIZE_OF_HEADER_IN_BYTES (32)  {version, command, param1, param2}; sampled on the start edge.
- payload_len  input  LEN_W  payload byte count; sampled on the start edge.
- payload_rd_en  output  1  one-cycle read strobe to the payload buffer.
- payload_addr  output  LEN_W  payload byte index, 0..payload_len-1.
- payload_rd_data  input  8  buffer read data; valid in the cycle after payload_rd_en.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data holds a byte.
- tx_last  output  1  final byte of the message; qualified by tx_valid.
- tx_ready  input  1  sink accepts the byte on a clock edge where tx_valid and tx_ready are both high.
- busy  output  1  a message is in progress.
- msg_done  output  1  one-cycle pulse after the final byte is accepted.
- len_error  output  1  one-cycle pulse when payload_len > MAX_PAYLOAD.
- drop  output  1  one-cycle pulse when a start edge arrives while busy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE; all outputs are 0.
  - The MSG_ready history register is cleared to 0, so MSG_ready held high through reset starts a message after reset is released.
- Start:
  - A start is IDLE && MSG_ready && !msg_ready_q, where msg_ready_q is MSG_ready registered.
  - On that edge, header and payload_len are latched and the byte counter is cleared.
  - If payload_len > MAX_PAYLOAD: go to IDLE, pulse len_error for one cycle, transmit nothing.
  - Otherwise go to HDR; busy and tx_valid are 1 from the next cycle.
- HDR:
  - tx_data = header byte k (k=0 is header[31:24]).
  - When byte k is accepted, byte k+1 is presented in the following cycle, so header throughput is 1 byte/cycle.
  - tx_last=1 on byte 3 only when the latched payload_len is 0.
  - After byte 3 is accepted: go to DONE if payload_len is 0, otherwise go to FETCH with tx_valid=0.
- FETCH: payload_rd_en=1 and payload_addr=i for exactly one cycle; next state WAIT.
- WAIT: payload_rd_data is captured into tx_data; next state SEND.
- SEND:
  - tx_valid=1, tx_last=(i==payload_len-1).
  - On acceptance, i increments; go to FETCH if more bytes remain, otherwise DONE.
  - Payload throughput is 1 byte per 3 cycles.
- DONE: msg_done=1 and busy=1 for one cycle; all tx signals are 0; then IDLE.
- Stream rule: while tx_valid && !tx_ready, tx_data and tx_last are held stable. tx_valid never drops without acceptance, except on reset.
- A start edge seen in any state other than IDLE produces a drop pulse. The message in progress is unaffected and the new one is discarded. MSG_ready must fall and rise again for the next message.
- header and payload_len changing after the start edge have no effect.
- The counter is LEN_W bits wide; payload_len == MAX_PAYLOAD addresses 0..MAX_PAYLOAD-1 with no wrap.
- All outputs are registered; no combinational path exists from any input to any output.

Decomposition:
- Shared defines include (existing): `SIZE_OF_HEADER_VARS, `SIZE_OF_HEADER_IN_BYTES, `PROTOCOL_VERSION, `ERROR_RESP_CMD.
- New defines in the same include: the serializer state encodings (IDLE, HDR, FETCH, WAIT, SEND, DONE, 3 bits) and `AUTH_MAX_PAYLOAD.
- A single module, with no sub-modules. The payload buffer model lives in the bench only.

Test Plan:
- Error response, no payload: header=32'h017F0300, len=0, tx_ready=1 -> tx bytes 01,7F,03,00 on 4 consecutive cycles; tx_last on 00; msg_done one cycle later; busy falls after that.
- Payload of 3, buffer holds AA,BB,CC: -> 4 header bytes, then reads at addr 0,1,2 with exactly one rd_en each; bytes AA,BB,CC each 3 cycles apart; tx_last on CC only.
- Backpressure: tx_ready low for 5 cycles mid-header and during payload byte BB -> tx_data/tx_last stable throughout; no duplicated or lost bytes; no extra rd_en.
- len=257 with MAX_PAYLOAD=256 -> len_error single pulse, tx_valid never asserted, busy stays 0; len=256 -> 260 bytes sent, last address 255.
- MSG_ready toggled 0->1 while busy -> drop pulse, the current message completes intact, no second message; MSG_ready held high after completion starts nothing.
- reset_n asserted during SEND -> all outputs 0 immediately; after release with MSG_ready=1, a fresh message starts from header byte 0.

Source files
------------

// File: rtl/auth_msg_serializer_pkg.sv
// Shared constants, state encoding and helpers for the auth message serializer.
// Header is {version, command, param1, param2}, sent MSB-first.
package auth_msg_serializer_pkg;

  localparam int SIZE_OF_HEADER_VARS     = 8;
  localparam int SIZE_OF_HEADER_IN_BYTES = 4;
  localparam int HDR_W = SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES;

  localparam logic [7:0] PROTOCOL_VERSION = 8'h01;
  localparam logic [7:0] ERROR_RESP_CMD   = 8'h7F;

  localparam int AUTH_MAX_PAYLOAD = 256;
  localparam int AUTH_LEN_W       = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5
  } ser_state_e;

  function automatic logic [7:0] hdr_byte(
    input logic [HDR_W-1:0] h,
    input logic [1:0]       k
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (k)
      2'd0: b = h[31:24];
      2'd1: b = h[23:16];
      2'd2: b = h[15:8];
      2'd3: b = h[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/auth_msg_serializer.sv
// Serializes a latched 4-byte header plus buffered payload into a
// valid/ready byte stream; one message in flight at a time.
module auth_msg_serializer
  import auth_msg_serializer_pkg::*;
#(
  parameter int MAX_PAYLOAD = AUTH_MAX_PAYLOAD,
  parameter int LEN_W       = AUTH_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MSG_ready,
  input  logic [HDR_W-1:0] header,
  input  logic [LEN_W-1:0] payload_len,
  output logic             payload_rd_en,
  output logic [LEN_W-1:0] payload_addr,
  input  logic [7:0]       payload_rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             busy,
  output logic             msg_done,
  output logic             len_error,
  output logic             drop
);

  ser_state_e       state_q, state_d;
  logic             msg_ready_q, msg_ready_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lerr_q, lerr_d;
  logic             drop_q, drop_d;

  logic start_edge;
  logic pay_last;

  assign start_edge = MSG_ready && !msg_ready_q;
  assign pay_last   = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    msg_ready_d = MSG_ready;
    hdr_d       = hdr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    rd_en_d     = 1'b0;
    done_d      = 1'b0;
    lerr_d      = 1'b0;
    drop_d      = start_edge && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = 8'h00;
        if (start_edge) begin
          hdr_d = header;
          len_d = payload_len;
          cnt_d = '0;
          idx_d = 2'd0;
          if (payload_len > LEN_W'(MAX_PAYLOAD)) begin
            lerr_d = 1'b1;
          end else begin
            state_d = ST_HDR;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            data_d  = header[31:24];
          end
        end
      end
      ST_HDR: begin
        if (tx_ready) begin
          if (idx_q == 2'd3) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 8'h00;
            if (len_q == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FETCH;
              rd_en_d = 1'b1;
              addr_d  = cnt_q;
            end
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = hdr_byte(hdr_q, idx_q + 2'd1);
            last_d = (idx_q == 2'd2) && (len_q == '0);
          end
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      // Buffer data arrives the cycle after the strobe.
      ST_WAIT: begin
        state_d = ST_SEND;
        data_d  = payload_rd_data;
        valid_d = 1'b1;
        last_d  = pay_last;
      end
      ST_SEND: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = 8'h00;
          cnt_d   = cnt_q + 1'b1;
          if (pay_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            rd_en_d = 1'b1;
            addr_d  = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      msg_ready_q <= 1'b0;
      hdr_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      addr_q      <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lerr_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_ready_q <= msg_ready_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lerr_q      <= lerr_d;
      drop_q      <= drop_d;
    end
  end

  assign payload_rd_en = rd_en_q;
  assign payload_addr  = addr_q;
  assign tx_data       = data_q;
  assign tx_valid      = valid_q;
  assign tx_last       = last_q;
  assign busy          = busy_q;
  assign msg_done      = done_q;
  assign len_error     = lerr_q;
  assign drop          = drop_q;

endmodule

// File: tb/tb_auth_msg_serializer.sv
// Directed bench for auth_msg_serializer with a registered payload buffer
// model and hand-computed byte sequences.
module tb_auth_msg_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MSG_ready;
  logic [31:0] header;
  logic [8:0]  payload_len;
  logic        payload_rd_en;
  logic [8:0]  payload_addr;
  logic [7:0]  payload_rd_data = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic        busy;
  logic        msg_done;
  logic        len_error;
  logic        drop;

  logic [7:0] mem [0:511];

  int checks   = 0;
  int failures = 0;

  auth_msg_serializer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .MSG_ready       (MSG_ready),
    .header          (header),
    .payload_len     (payload_len),
    .payload_rd_en   (payload_rd_en),
    .payload_addr    (payload_addr),
    .payload_rd_data (payload_rd_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_last         (tx_last),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .msg_done        (msg_done),
    .len_error       (len_error),
    .drop            (drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (payload_rd_en) payload_rd_data <= mem[payload_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rden"}, 32'(payload_rd_en), 32'd0);
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] d,
                          input logic l);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
    chk({tag, "_last"}, 32'(tx_last), 32'(l));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic hdr_b(input string tag, input logic [7:0] d,
                       input logic l);
    chk_byte(tag, d, l);
    tick;
  endtask

  task automatic send_hdr(input string tag, input logic [31:0] h,
                          input logic len0);
    hdr_b({tag, "_h0"}, h[31:24], 1'b0);
    hdr_b({tag, "_h1"}, h[23:16], 1'b0);
    hdr_b({tag, "_h2"}, h[15:8], 1'b0);
    hdr_b({tag, "_h3"}, h[7:0], len0);
  endtask

  task automatic pay_b(input string tag, input int a, input logic [7:0] d,
                       input logic l);
    chk({tag, "_fetch_rden"}, 32'(payload_rd_en), 32'd1);
    chk({tag, "_fetch_addr"}, 32'(payload_addr), 32'(a));
    chk({tag, "_fetch_valid"}, 32'(tx_valid), 32'd0);
    tick;
    chk({tag, "_wait_rden"}, 32'(payload_rd_en), 32'd0);
    chk({tag, "_wait_valid"}, 32'(tx_valid), 32'd0);
    tick;
    chk({tag, "_send_rden"}, 32'(payload_rd_en), 32'd0);
    chk_byte({tag, "_send"}, d, l);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 32'(msg_done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_done_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_done_last"}, 32'(tx_last), 32'd0);
    tick;
    chk({tag, "_post_done"}, 32'(msg_done), 32'd0);
    chk_idle({tag, "_post"});
  endtask

  // Leaves the first header byte on the stream; then scrambles inputs.
  task automatic start(input logic [31:0] h, input logic [8:0] len);
    MSG_ready = 1'b0;
    tick;
    header      = h;
    payload_len = len;
    MSG_ready   = 1'b1;
    tick;
    header      = 32'hFFFF_FFFF;
    payload_len = 9'd0;
  endtask

  initial begin
    reset_n     = 1'b0;
    MSG_ready   = 1'b0;
    header      = 32'h0;
    payload_len = 9'd0;
    tx_ready    = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'hAA;
    mem[1] = 8'hBB;
    mem[2] = 8'hCC;
    tick;
    chk_idle("rst");
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_last", 32'(tx_last), 32'd0);
    chk("rst_done", 32'(msg_done), 32'd0);
    chk("rst_lerr", 32'(len_error), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    reset_n = 1'b1;
    tick;

    // Error response, no payload
    start(32'h017F_0300, 9'd0);
    send_hdr("err", 32'h017F_0300, 1'b1);
    chk_done("err");
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_idle("err_hold");
    end

    // Three payload bytes
    start(32'h1234_5678, 9'd3);
    send_hdr("p3", 32'h1234_5678, 1'b0);
    pay_b("p3_0", 0, 8'hAA, 1'b0);
    tick;
    pay_b("p3_1", 1, 8'hBB, 1'b0);
    tick;
    pay_b("p3_2", 2, 8'hCC, 1'b1);
    tick;
    chk_done("p3");

    // Backpressure mid-header and on payload byte BB
    start(32'hC0FF_EE11, 9'd3);
    hdr_b("bp_h0", 8'hC0, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_byte("bp_h1_stall", 8'hFF, 1'b0);
      tick;
    end
    tx_ready = 1'b1;
    hdr_b("bp_h1", 8'hFF, 1'b0);
    hdr_b("bp_h2", 8'hEE, 1'b0);
    hdr_b("bp_h3", 8'h11, 1'b0);
    pay_b("bp_0", 0, 8'hAA, 1'b0);
    tick;
    pay_b("bp_1", 1, 8'hBB, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_byte("bp_1_stall", 8'hBB, 1'b0);
      chk("bp_1_stall_rden", 32'(payload_rd_en), 32'd0);
    end
    tx_ready = 1'b1;
    tick;
    pay_b("bp_2", 2, 8'hCC, 1'b1);
    tick;
    chk_done("bp");

    // Oversized request is rejected
    MSG_ready = 1'b0;
    tick;
    header      = 32'hABCD_EF01;
    payload_len = 9'd257;
    MSG_ready   = 1'b1;
    tick;
    chk("lerr_pulse", 32'(len_error), 32'd1);
    chk_idle("lerr");
    tick;
    chk("lerr_clear", 32'(len_error), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk_idle("lerr_hold");
      tick;
    end

    // Maximum payload
    mem[0] = 8'h5A;
    mem[1] = 8'h5B;
    mem[2] = 8'h58;
    start(32'h0203_0405, 9'd256);
    send_hdr("max", 32'h0203_0405, 1'b0);
    for (int i = 0; i < 256; i++) begin
      pay_b("max", i, 8'(i) ^ 8'h5A, i == 255);
      tick;
    end
    chk_done("max");

    // Start edge while busy is dropped
    mem[0] = 8'h3C;
    start(32'h0A0B_0C0D, 9'd1);
    MSG_ready = 1'b0;
    hdr_b("drp_h0", 8'h0A, 1'b0);
    MSG_ready = 1'b1;
    chk("drp_before", 32'(drop), 32'd0);
    hdr_b("drp_h1", 8'h0B, 1'b0);
    chk("drp_pulse", 32'(drop), 32'd1);
    hdr_b("drp_h2", 8'h0C, 1'b0);
    chk("drp_clear", 32'(drop), 32'd0);
    hdr_b("drp_h3", 8'h0D, 1'b0);
    pay_b("drp_p", 0, 8'h3C, 1'b1);
    tick;
    chk_done("drp");
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_idle("drp_hold");
      chk("drp_hold_drop", 32'(drop), 32'd0);
    end

    // Reset during SEND, MSG_ready held high through it
    mem[0] = 8'h77;
    start(32'hDEAD_BEEF, 9'd2);
    send_hdr("rs", 32'hDEAD_BEEF, 1'b0);
    tx_ready = 1'b0;
    pay_b("rs_p", 0, 8'h77, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_idle("rs_async");
    chk("rs_async_data", 32'(tx_data), 32'd0);
    chk("rs_async_last", 32'(tx_last), 32'd0);
    chk("rs_async_done", 32'(msg_done), 32'd0);
    #1;
    reset_n     = 1'b1;
    tx_ready    = 1'b1;
    header      = 32'h0102_0304;
    payload_len = 9'd0;
    tick;
    send_hdr("rs_new", 32'h0102_0304, 1'b1);
    chk_done("rs_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
